bf16_accel_dispatch: RTL

Parametrised issue/completion engine for the BF16 accelerator. It accepts operations over a valid/ready handshake and decodes each one to an execution class: conversion, min/max, FMA, or illegal. It issues the operation to the matching external unit, which has a fixed, parameterised latency. Results are returned strictly in order through an output FIFO with backpressure, and the engine keeps a sticky FPCSR. It replaces the single-shot enable/valid decode in the accelerator top.

---
 rtl/bf16_accel_pkg.sv | 33 +++
 rtl/bf16_accel_dispatch_if.sv | 30 +++
 rtl/bf16_sync_fifo.sv | 39 +++
 rtl/bf16_accel_dispatch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bf16_accel_pkg.sv
// Shared types, opcodes and decode helper for the BF16 accelerator dispatch engine.
package bf16_accel_pkg;

  typedef enum logic [1:0] {
    CONV    = 2'd0,
    MINMAX  = 2'd1,
    FMA     = 2'd2,
    ILLEGAL = 2'd3
  } op_class_e;

  localparam logic [3:0] OP_F2BF   = 4'b0000;
  localparam logic [3:0] OP_BF2F   = 4'b0001;
  localparam logic [3:0] OP_MIN    = 4'b0010;
  localparam logic [3:0] OP_MAX    = 4'b0011;
  localparam logic [3:0] OP_FMADD  = 4'b0100;
  localparam logic [3:0] OP_FMSUB  = 4'b0101;
  localparam logic [3:0] OP_FNMADD = 4'b0110;
  localparam logic [3:0] OP_FNMSUB = 4'b0111;
  localparam logic [3:0] OP_FMUL   = 4'b1000;
  localparam logic [3:0] OP_FADD   = 4'b1001;
  localparam logic [3:0] OP_FSUB   = 4'b1010;

  localparam logic [31:0] FLAG_NV = 32'h0000_0010;

  // Opcode ranges map contiguously onto execution classes.
  function automatic op_class_e decode_class(input logic [3:0] op);
    if (op <= OP_BF2F)      return CONV;
    else if (op <= OP_MAX)  return MINMAX;
    else if (op <= OP_FSUB) return FMA;
    else                    return ILLEGAL;
  endfunction

endpackage

// File: rtl/bf16_accel_dispatch_if.sv
// Request and result handshake bundle of the dispatch engine.
interface bf16_accel_dispatch_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] operand_c;
  logic [3:0]       operation;
  logic [TAG_W-1:0] tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [31:0]      fpcsr;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_operation;

  modport master (
    output in_valid, operand_a, operand_b, operand_c, operation, tag, out_ready,
    input  in_ready, out_valid, result, fpcsr, out_tag, out_operation
  );

  modport slave (
    input  in_valid, operand_a, operand_b, operand_c, operation, tag, out_ready,
    output in_ready, out_valid, result, fpcsr, out_tag, out_operation
  );
endinterface

// File: rtl/bf16_sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero when empty.
module bf16_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage write, no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/bf16_accel_dispatch.sv
// In-order issue/completion engine: decode, unit issue, fixed-latency capture,
// output FIFO with credit flow control and sticky flag accumulation.
module bf16_accel_dispatch
  import bf16_accel_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CONV_LAT   = 1,
  parameter int unsigned MINMAX_LAT = 1,
  parameter int unsigned FMA_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bf16_accel_dispatch_if.slave  bus,
  output logic                  conv_issue,
  output logic                  maxmin_issue,
  output logic                  fma_issue,
  output logic [3:0]            unit_operation,
  output logic [WIDTH-1:0]      unit_operand_a,
  output logic [WIDTH-1:0]      unit_operand_b,
  output logic [WIDTH-1:0]      unit_operand_c,
  input  logic [WIDTH-1:0]      conv_result,
  input  logic [WIDTH-1:0]      maxmin_result,
  input  logic [WIDTH-1:0]      fma_result,
  input  logic [31:0]           conv_fpcsr,
  input  logic [31:0]           maxmin_fpcsr,
  input  logic [31:0]           fma_fpcsr,
  input  logic                  clear_flags,
  output logic [31:0]           sticky_fpcsr,
  output logic                  busy
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    op_class_e        cls;
    logic [TAG_W-1:0] tag;
    logic [3:0]       op;
  } meta_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [31:0]      fpcsr;
    logic [TAG_W-1:0] tag;
    logic [3:0]       op;
  } entry_t;

  op_class_e        in_class;
  logic [3:0]       in_lat;
  logic [3:0]       rem;
  logic [15:0]      cmpl_dl;
  logic             accept;
  logic             capture;
  logic             out_pop;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  meta_t            meta_in;
  meta_t            meta_head;
  entry_t           cap_entry;
  entry_t           out_head;

  // Class and latency of the op currently presented.
  always_comb begin
    in_class = decode_class(bus.operation);
    case (in_class)
      CONV:    in_lat = 4'(CONV_LAT);
      MINMAX:  in_lat = 4'(MINMAX_LAT);
      FMA:     in_lat = 4'(FMA_LAT);
      default: in_lat = 4'd1;
    endcase
  end

  assign credit_used  = (CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_count);
  assign bus.in_ready = (credit_used < (CNT_W+1)'(FIFO_DEPTH)) && (in_lat >= rem);
  assign accept       = bus.in_valid && bus.in_ready;
  assign capture      = cmpl_dl[0];
  assign out_pop      = bus.out_valid && bus.out_ready;

  // Ordering counter and completion-valid delay line; bit k set means capture in k cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      cmpl_dl <= '0;
    end else begin
      rem     <= accept ? in_lat : ((rem != '0) ? rem - 4'd1 : '0);
      cmpl_dl <= (cmpl_dl >> 1) | (accept ? (16'd1 << in_lat) : '0);
    end
  end

  // Registered unit strobes and operand copies.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_issue     <= 1'b0;
      maxmin_issue   <= 1'b0;
      fma_issue      <= 1'b0;
      unit_operation <= '0;
      unit_operand_a <= '0;
      unit_operand_b <= '0;
      unit_operand_c <= '0;
    end else begin
      conv_issue   <= accept && (in_class == CONV);
      maxmin_issue <= accept && (in_class == MINMAX);
      fma_issue    <= accept && (in_class == FMA);
      if (accept) begin
        unit_operation <= bus.operation;
        unit_operand_a <= bus.operand_a;
        unit_operand_b <= bus.operand_b;
        unit_operand_c <= bus.operand_c;
      end
    end
  end

  assign meta_in = '{cls: in_class, tag: bus.tag, op: bus.operation};

  // The metadata queue holds exactly the in-flight ops, so its count is the in-flight counter.
  bf16_sync_fifo #(
    .WIDTH ($bits(meta_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_meta_q (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (meta_in),
    .pop       (capture),
    .rd_data   (meta_head),
    .count     (inflight)
  );

  // Select the completing unit's result and flags for the oldest in-flight op.
  always_comb begin
    cap_entry.tag = meta_head.tag;
    cap_entry.op  = meta_head.op;
    case (meta_head.cls)
      CONV: begin
        cap_entry.result = conv_result;
        cap_entry.fpcsr  = conv_fpcsr;
      end
      MINMAX: begin
        cap_entry.result = maxmin_result;
        cap_entry.fpcsr  = maxmin_fpcsr;
      end
      FMA: begin
        cap_entry.result = fma_result;
        cap_entry.fpcsr  = fma_fpcsr;
      end
      default: begin
        cap_entry.result = '0;
        cap_entry.fpcsr  = FLAG_NV;
      end
    endcase
  end

  bf16_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (cap_entry),
    .pop       (out_pop),
    .rd_data   (out_head),
    .count     (fifo_count)
  );

  assign bus.out_valid     = (fifo_count != '0);
  assign bus.result        = out_head.result;
  assign bus.fpcsr         = out_head.fpcsr;
  assign bus.out_tag       = out_head.tag;
  assign bus.out_operation = out_head.op;
  assign busy              = (inflight != '0) || (fifo_count != '0);

  // Sticky flags: clear applies before the popped flags are ORed in.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_fpcsr <= '0;
    end else if (clear_flags || out_pop) begin
      sticky_fpcsr <= (clear_flags ? '0 : sticky_fpcsr) | (out_pop ? out_head.fpcsr : '0);
    end
  end
endmodule
